proc_mc: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle toy processor.
- Keeps the 16-bit instruction encoding: [15:12] reg_select, [11:8] op, [7:0] imm.
- Generalises data width, address width and register count; runs every instruction through a fetch/execute/memory FSM.
- Talks to a single shared instruction/data memory port with a req/ack handshake.
- Adds load, store, add-immediate, jump, branch and halt.

---
 rtl/proc_mc.sv | 151 +++++++++++++++
 tb/tb_proc_mc.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/proc_mc.sv
// proc_mc: parametrised multi-cycle toy processor (FETCH/EXEC/MEM/HALT) on a shared req/ack memory port.
// Optional macro PROC_MC_BRANCH_EN builds JMP (op 7) and BEQZ (op 8); without it both decode as NOP.
module proc_mc #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
    localparam logic [4:0] LP_NREGS = 5'(NUM_REGS);
    localparam logic [3:0] OP_OUTI = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_LI   = 4'h3;
    localparam logic [3:0] OP_OUTR = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
`ifdef PROC_MC_BRANCH_EN
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_BEQZ = 4'h8;
`endif
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t            r_state, w_state_nxt;
    logic [15:0]       r_instr, w_instr_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [DATA_W-1:0] r_out, w_out_nxt;
    logic              r_out_valid, w_out_valid_nxt;
    logic [DATA_W-1:0] r_regs [16];
    logic              w_reg_we;
    logic [DATA_W-1:0] w_reg_wdata;
    logic [3:0]        w_sel;
    logic [3:0]        w_op;
    logic [DATA_W-1:0] w_imm_d;
    logic [ADDR_W-1:0] w_imm_a;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [DATA_W-1:0] w_reg_rd;
    logic              w_is_st;

    assign w_sel    = r_instr[15:12];
    assign w_op     = r_instr[11:8];
    assign w_imm_d  = DATA_W'(r_instr[7:0]);
    assign w_imm_a  = ADDR_W'(r_instr[7:0]);
    assign w_pc_inc = r_pc + ADDR_W'(1);
    // Registers at or above NUM_REGS are never written, so reading them yields 0.
    assign w_reg_rd = r_regs[w_sel];
    assign w_is_st  = (r_state == S_MEM) && (w_op == OP_ST);

    // Memory request is a pure function of state; reset gates it so a pending request drops at once.
    assign mem_req     = rst && ((r_state == S_FETCH) || (r_state == S_MEM));
    assign mem_we      = w_is_st;
    assign mem_addr    = (r_state == S_MEM) ? w_imm_a : (r_state == S_FETCH) ? r_pc : '0;
    assign mem_wr_data = w_is_st ? w_reg_rd : '0;
    assign out         = r_out;
    assign out_valid   = r_out_valid;
    assign pc          = r_pc;
    assign halted      = (r_state == S_HALT);

    // Next-state, decode and register-write selection.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_instr_nxt     = r_instr;
        w_out_nxt       = r_out;
        w_out_valid_nxt = 1'b0;
        w_reg_we        = 1'b0;
        w_reg_wdata     = w_imm_d;
        case (r_state)
            S_FETCH: if (mem_ack) begin
                w_instr_nxt = 16'(mem_rd_data);
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_state_nxt = S_FETCH;
                w_pc_nxt    = w_pc_inc;
                case (w_op)
                    OP_OUTI: begin
                        w_out_nxt       = w_imm_d;
                        w_out_valid_nxt = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        w_state_nxt = S_MEM;
                        w_pc_nxt    = r_pc;
                    end
                    OP_LI: w_reg_we = 1'b1;
                    OP_OUTR: begin
                        w_out_nxt       = w_reg_rd;
                        w_out_valid_nxt = 1'b1;
                    end
                    OP_ADDI: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = w_reg_rd + w_imm_d;
                    end
`ifdef PROC_MC_BRANCH_EN
                    OP_JMP: w_pc_nxt = w_imm_a;
                    OP_BEQZ: w_pc_nxt = (w_reg_rd == '0) ? w_imm_a : w_pc_inc;
`endif
                    OP_HALT: begin
                        w_state_nxt = S_HALT;
                        w_pc_nxt    = r_pc;
                    end
                    default: ;
                endcase
            end
            S_MEM: if (mem_ack) begin
                w_state_nxt = S_FETCH;
                w_pc_nxt    = w_pc_inc;
                w_reg_we    = (w_op == OP_LD);
                w_reg_wdata = mem_rd_data;
            end
            default: ;
        endcase
    end

    // State, pc, instruction and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_FETCH;
            r_pc        <= '0;
            r_instr     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_instr     <= w_instr_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Register file; writes to unimplemented indices are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
        end else if (w_reg_we && ({1'b0, w_sel} < LP_NREGS)) begin
            r_regs[w_sel] <= w_reg_wdata;
        end
    end
endmodule

// File: tb/tb_proc_mc.sv
// tb_proc_mc: directed self-checking bench for proc_mc (DATA_W=16, ADDR_W=8, NUM_REGS=4).
module tb_proc_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req, mem_we, mem_ack;
    logic [7:0]  mem_addr, pc;
    logic [15:0] mem_wr_data, mem_rd_data, out;
    logic        out_valid, halted;

    logic [15:0] mem [256];
    int          wcnt = 0;
    int          wait_n = 0;
    logic [7:0]  wait_addr = 8'h40;
    logic        ack_extra = 1'b0;

    int          n_pass = 0;
    int          n_total = 0;
    int          halt_at;
    logic [15:0] outs [$];
    logic        tr_req [600];
    logic        tr_we [600];
    logic        tr_ov [600];
    logic [7:0]  tr_addr [600];
    logic [7:0]  tr_pc [600];
    logic [15:0] tr_wd [600];
    logic [15:0] tr_out [600];

    proc_mc #(.DATA_W(16), .ADDR_W(8), .NUM_REGS(4)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack),
        .out(out), .out_valid(out_valid), .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    // Memory responder: reads are combinational, wait states only on reads of wait_addr.
    assign mem_rd_data = mem[mem_addr];
    assign mem_ack = ack_extra | (mem_req && (wcnt >= ((mem_addr == wait_addr && !mem_we) ? wait_n : 0)));
    always @(posedge clk) wcnt <= (!rst || !mem_req || mem_ack) ? 0 : wcnt + 1;

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    // Hold reset for two cycles, release at a falling edge; the sample point is then cycle 0.
    task automatic restart();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    // Sample one record per cycle (1 ns after the falling edge); commit stores; stop 3 cycles after halt.
    task automatic run(input int max_c);
        halt_at = -1;
        outs.delete();
        for (int k = 0; k < max_c; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            tr_req[k] = mem_req; tr_we[k] = mem_we; tr_addr[k] = mem_addr; tr_wd[k] = mem_wr_data;
            tr_ov[k] = out_valid; tr_out[k] = out; tr_pc[k] = pc;
            if (out_valid) outs.push_back(out);
            if (mem_req && mem_we && mem_ack) mem[mem_addr] = mem_wr_data;
            if (halted && halt_at < 0) halt_at = k;
            if (halt_at >= 0 && k >= halt_at + 3) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_total++; if (mem_req !== 1'b0) $display("FAIL rst_req: got %b expected 0", mem_req); else n_pass++;
        n_total++; if (mem_we !== 1'b0) $display("FAIL rst_we: got %b expected 0", mem_we); else n_pass++;
        n_total++; if (mem_addr !== 8'h00) $display("FAIL rst_addr: got %h expected 00", mem_addr); else n_pass++;
        n_total++; if (mem_wr_data !== 16'h0000) $display("FAIL rst_wd: got %h expected 0000", mem_wr_data); else n_pass++;
        n_total++; if (out !== 16'h0000) $display("FAIL rst_out: got %h expected 0000", out); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_ov: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (pc !== 8'h00) $display("FAIL rst_pc: got %h expected 00", pc); else n_pass++;
        n_total++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b expected 0", halted); else n_pass++;
    endtask

    task automatic test_basic();
        clear_mem();
        wait_n = 0;
        mem[0] = 16'h235A; mem[1] = 16'h2400; mem[2] = 16'h0F00;
        restart();
        run(40);
        n_total++; if (tr_req[0] !== 1'b1 || tr_addr[0] !== 8'h00) $display("FAIL basic_fetch0: got req %b addr %h expected 1 00", tr_req[0], tr_addr[0]); else n_pass++;
        n_total++; if (tr_ov[3] !== 1'b0 || tr_ov[4] !== 1'b1 || tr_ov[5] !== 1'b0) $display("FAIL basic_ov_pulse: got %b%b%b expected 010", tr_ov[3], tr_ov[4], tr_ov[5]); else n_pass++;
        n_total++; if (tr_out[4] !== 16'h005A) $display("FAIL basic_out: got %h expected 005a", tr_out[4]); else n_pass++;
        n_total++; if (halt_at !== 6) $display("FAIL basic_halt_cycle: got %0d expected 6", halt_at); else n_pass++;
        n_total++; if (outs.size() !== 1) $display("FAIL basic_ov_count: got %0d expected 1", outs.size()); else n_pass++;
        n_total++; if (tr_pc[6] !== 8'h02) $display("FAIL basic_halt_pc: got %h expected 02", tr_pc[6]); else n_pass++;
        for (int k = 6; k <= 9; k++) begin
            n_total++; if (tr_req[k] !== 1'b0) $display("FAIL basic_no_req_c%0d: got %b expected 0", k, tr_req[k]); else n_pass++;
        end
        ack_extra = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            n_total++;
            if (mem_req !== 1'b0 || halted !== 1'b1 || pc !== 8'h02)
                $display("FAIL halt_stray_ack: got req %b halted %b pc %h expected 0 1 02", mem_req, halted, pc);
            else n_pass++;
        end
        ack_extra = 1'b0;
    endtask

    task automatic test_store_load();
        clear_mem();
        wait_n = 3;
        mem[0] = 16'h1230; mem[1] = 16'h1540; mem[2] = 16'h3240; mem[3] = 16'h3400; mem[4] = 16'h0F00;
        mem[8'h30] = 16'h1234;
        restart();
        run(60);
        n_total++; if (tr_req[5] !== 1'b1 || tr_we[5] !== 1'b1 || tr_addr[5] !== 8'h40) $display("FAIL st_req: got req %b we %b addr %h expected 1 1 40", tr_req[5], tr_we[5], tr_addr[5]); else n_pass++;
        n_total++; if (tr_wd[5] !== 16'h1234) $display("FAIL st_wdata: got %h expected 1234", tr_wd[5]); else n_pass++;
        n_total++; if (mem[8'h40] !== 16'h1234) $display("FAIL st_mem: got %h expected 1234", mem[8'h40]); else n_pass++;
        n_total++; if (tr_req[11] !== 1'b1 || tr_we[11] !== 1'b0 || tr_addr[11] !== 8'h40) $display("FAIL ld_wait: got req %b we %b addr %h expected 1 0 40", tr_req[11], tr_we[11], tr_addr[11]); else n_pass++;
        n_total++; if (tr_req[12] !== 1'b1 || tr_addr[12] !== 8'h03) $display("FAIL ld_len: got req %b addr %h expected 1 03", tr_req[12], tr_addr[12]); else n_pass++;
        n_total++; if (halt_at !== 16) $display("FAIL stld_halt_cycle: got %0d expected 16", halt_at); else n_pass++;
        n_total++; if (outs.size() !== 1 || outs[0] !== 16'h1234) $display("FAIL ld_value: got n=%0d %h expected 1 1234", outs.size(), outs[0]); else n_pass++;
    endtask

    task automatic test_addi_wrap();
        clear_mem();
        wait_n = 0;
        mem[0] = 16'h2231; mem[1] = 16'h2620; mem[2] = 16'h2400; mem[3] = 16'h33FF;
        mem[4] = 16'h36FF; mem[5] = 16'h36FF; mem[6] = 16'h36FF; mem[7] = 16'h3400; mem[8] = 16'h0F00;
        mem[8'h31] = 16'hFFF0;
        restart();
        run(60);
        n_total++; if (outs.size() !== 2) $display("FAIL addi_count: got %0d expected 2", outs.size()); else n_pass++;
        n_total++; if (outs[0] !== 16'h0010) $display("FAIL addi_wrap: got %h expected 0010", outs[0]); else n_pass++;
        n_total++; if (outs[1] !== 16'h03FC) $display("FAIL addi_sum: got %h expected 03fc", outs[1]); else n_pass++;
    endtask

    task automatic test_branch();
        logic [7:0]  exp_pc;
        logic [15:0] exp_out;
`ifdef PROC_MC_BRANCH_EN
        exp_pc = 8'h31; exp_out = 16'h0002;
`else
        exp_pc = 8'h03; exp_out = 16'h0001;
`endif
        clear_mem();
        mem[0] = 16'h0810; mem[1] = 16'h0730; mem[2] = 16'h0101; mem[3] = 16'h0F00;
        mem[8'h10] = 16'h1305; mem[8'h11] = 16'h1820; mem[8'h12] = 16'h0730;
        mem[8'h30] = 16'h0102; mem[8'h31] = 16'h0F00;
        restart();
        run(80);
        n_total++; if (halt_at < 0 || tr_pc[halt_at] !== exp_pc) $display("FAIL branch_pc: got %h (halt %0d) expected %h", tr_pc[(halt_at < 0) ? 0 : halt_at], halt_at, exp_pc); else n_pass++;
        n_total++; if (outs.size() !== 1 || outs[0] !== exp_out) $display("FAIL branch_out: got n=%0d %h expected 1 %h", outs.size(), outs[0], exp_out); else n_pass++;
    endtask

    task automatic test_reset_mid_mem();
        clear_mem();
        wait_n = 255;
        mem[0] = 16'h1399; mem[1] = 16'h2240;
        restart();
        run(5);
        n_total++; if (tr_req[4] !== 1'b1 || tr_addr[4] !== 8'h40) $display("FAIL mid_mem_pending: got req %b addr %h expected 1 40", tr_req[4], tr_addr[4]); else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++; if (mem_req !== 1'b0) $display("FAIL async_req_drop: got %b expected 0", mem_req); else n_pass++;
        n_total++; if (pc !== 8'h00 || out !== 16'h0000 || halted !== 1'b0) $display("FAIL async_state: got pc %h out %h halted %b expected 00 0000 0", pc, out, halted); else n_pass++;
        n_total++; if (mem_addr !== 8'h00 || mem_we !== 1'b0) $display("FAIL async_addr: got addr %h we %b expected 00 0", mem_addr, mem_we); else n_pass++;
        mem[0] = 16'h1400; mem[1] = 16'h0F00;
        wait_n = 0;
        restart();
        run(30);
        n_total++; if (tr_req[0] !== 1'b1 || tr_addr[0] !== 8'h00) $display("FAIL post_rst_fetch: got req %b addr %h expected 1 00", tr_req[0], tr_addr[0]); else n_pass++;
        n_total++; if (outs.size() !== 1 || outs[0] !== 16'h0000) $display("FAIL post_rst_reg: got n=%0d %h expected 1 0000", outs.size(), outs[0]); else n_pass++;
        n_total++; if (halt_at !== 4) $display("FAIL post_rst_halt: got %0d expected 4", halt_at); else n_pass++;
    endtask

    task automatic test_num_regs();
        clear_mem();
        mem[0] = 16'h0177; mem[1] = 16'h9307; mem[2] = 16'h9400; mem[3] = 16'h0F00;
        restart();
        run(40);
        n_total++; if (outs.size() !== 2) $display("FAIL oob_count: got %0d expected 2", outs.size()); else n_pass++;
        n_total++; if (outs[0] !== 16'h0077) $display("FAIL outi: got %h expected 0077", outs[0]); else n_pass++;
        n_total++; if (outs[1] !== 16'h0000) $display("FAIL oob_read: got %h expected 0000", outs[1]); else n_pass++;
    endtask

    task automatic test_pc_wrap();
        clear_mem();
        restart();
        run(515);
        n_total++; if (tr_pc[510] !== 8'hFF || tr_addr[510] !== 8'hFF) $display("FAIL pc_ff: got pc %h addr %h expected ff ff", tr_pc[510], tr_addr[510]); else n_pass++;
        n_total++; if (tr_pc[512] !== 8'h00 || tr_addr[512] !== 8'h00 || tr_req[512] !== 1'b1) $display("FAIL pc_wrap: got pc %h addr %h req %b expected 00 00 1", tr_pc[512], tr_addr[512], tr_req[512]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_store_load();
        test_addi_wrap();
        test_branch();
        test_reset_mid_mem();
        test_num_regs();
        test_pc_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
